// File: rtl/hamming_pkg.sv
// hamming_pkg: shared SECDED codeword layout, encoder FSM states and the 11->16 bit encode function
package hamming_pkg;
   localparam int P0 = 0;
   localparam int P1 = 1;
   localparam int P2 = 2;
   localparam int P4 = 4;
   localparam int P8 = 8;
   typedef enum logic [2:0] {
      S_IDLE, S_RD_LO, S_RD_HI, S_CAP, S_WR_LO, S_WR_HI, S_DONE
   } enc_state_e;
   // d[k] is data bit k as numbered by the decoder, so cw bit positions 1,2,4,8 carry parity
   function automatic logic [15:0] encode11(input logic [11:1] d);
      logic p8, p4, p2, p1, p0;
      p8 = ^d[11:5];
      p4 = (^d[11:8]) ^ (^d[4:2]);
      p2 = d[11] ^ d[10] ^ d[7] ^ d[6] ^ d[4] ^ d[3] ^ d[1];
      p1 = d[11] ^ d[9] ^ d[7] ^ d[5] ^ d[4] ^ d[2] ^ d[1];
      p0 = (^d) ^ p8 ^ p4 ^ p2 ^ p1;
      return {d[11:5], p8, d[4:2], p4, d[1], p2, p1, p0};
   endfunction
endpackage

// File: rtl/hamming_enc11.sv
// hamming_enc11: combinational 11-bit message to 16-bit SECDED codeword
module hamming_enc11
   import hamming_pkg::*;
(
   input  logic [10:0] msg_i,
   output logic [15:0] cw_o
);
   assign cw_o = encode11(msg_i);
endmodule

// File: rtl/hamming_enc_engine.sv
// hamming_enc_engine: byte-wide bus master reading NUM_MSG 11-bit messages and writing SECDED codewords
module hamming_enc_engine
   import hamming_pkg::*;
#(
   parameter int NUM_MSG  = 15,
   parameter int SRC_BASE = 0,
   parameter int DST_BASE = 30,
   parameter int ADDR_W   = 8
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              req,
   output logic              done,
   output logic [ADDR_W-1:0] mem_addr,
   output logic              mem_wr_en,
   output logic [7:0]        mem_wr_data,
   input  logic [7:0]        mem_rd_data
);
   localparam int IW = NUM_MSG > 1 ? $clog2(NUM_MSG) : 1;
   enc_state_e state_q, state_d;
   logic [IW-1:0] idx_q, idx_d;
   logic [7:0] lo_q, lo_d;
   logic [2:0] hi_q, hi_d;
   logic [15:0] cw;
   logic [ADDR_W-1:0] off, src_a, dst_a;
   hamming_enc11 u_enc (.msg_i({hi_q, lo_q}), .cw_o(cw));
   assign off   = ADDR_W'({idx_q, 1'b0});
   assign src_a = ADDR_W'(SRC_BASE) + off;
   assign dst_a = ADDR_W'(DST_BASE) + off;
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= S_IDLE;
         idx_q   <= '0;
         lo_q    <= '0;
         hi_q    <= '0;
      end else begin
         state_q <= state_d;
         idx_q   <= idx_d;
         lo_q    <= lo_d;
         hi_q    <= hi_d;
      end
   end
   // outputs decode straight from the state so a reset returns them to zero on the next cycle
   always_comb begin
      state_d     = state_q;
      idx_d       = idx_q;
      lo_d        = lo_q;
      hi_d        = hi_q;
      mem_addr    = '0;
      mem_wr_en   = 1'b0;
      mem_wr_data = '0;
      done        = 1'b0;
      unique case (state_q)
         S_IDLE: if (req) begin
            state_d = S_RD_LO;
            idx_d   = '0;
         end
         S_RD_LO: begin
            mem_addr = src_a;
            state_d  = S_RD_HI;
         end
         S_RD_HI: begin
            mem_addr = src_a + ADDR_W'(1);
            lo_d     = mem_rd_data;
            state_d  = S_CAP;
         end
         S_CAP: begin
            hi_d    = mem_rd_data[2:0];
            state_d = S_WR_LO;
         end
         S_WR_LO: begin
            mem_addr    = dst_a;
            mem_wr_en   = 1'b1;
            mem_wr_data = cw[7:0];
            state_d     = S_WR_HI;
         end
         S_WR_HI: begin
            mem_addr    = dst_a + ADDR_W'(1);
            mem_wr_en   = 1'b1;
            mem_wr_data = cw[15:8];
            state_d     = idx_q == IW'(NUM_MSG - 1) ? S_DONE : S_RD_LO;
            idx_d       = idx_q == IW'(NUM_MSG - 1) ? idx_q : idx_q + IW'(1);
         end
         S_DONE: begin
            done = 1'b1;
            if (req) begin
               state_d = S_RD_LO;
               idx_d   = '0;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end
endmodule

// File: tb/tb_hamming_enc_engine.sv
// tb_hamming_enc_engine: directed checks of the encoder engine against a byte memory model
module tb_hamming_enc_engine;
   localparam int SRC = 0;
   localparam int DST = 30;
   logic clk = 1'b0;
   logic reset, req;
   logic done, mem_wr_en;
   logic [7:0] mem_addr, mem_wr_data, mem_rd_data;
   logic [7:0] mem [256];
   logic ld_en;
   logic [7:0] ld_addr, ld_data;
   logic [15:0] exp_cw [15];
   int checks = 0;
   int errors = 0;
   int wr_cnt = 0;
   int lat, w0;

   always #5 clk = ~clk;

   hamming_enc_engine dut (
      .clk(clk), .reset(reset), .req(req), .done(done),
      .mem_addr(mem_addr), .mem_wr_en(mem_wr_en),
      .mem_wr_data(mem_wr_data), .mem_rd_data(mem_rd_data)
   );

   always @(posedge clk) begin
      if (mem_wr_en) mem[mem_addr] <= mem_wr_data;
      else if (ld_en) mem[ld_addr] <= ld_data;
      mem_rd_data <= mem[mem_addr];
      if (mem_wr_en) wr_cnt <= wr_cnt + 1;
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   task automatic poke(input int a, input logic [7:0] v);
      @(negedge clk);
      ld_en = 1'b1;
      ld_addr = a[7:0];
      ld_data = v;
      @(posedge clk);
      #1 ld_en = 1'b0;
   endtask

   task automatic load_msg(input int i, input logic [7:0] lo, input logic [7:0] hi);
      poke(SRC + 2 * i, lo);
      poke(SRC + 2 * i + 1, hi);
   endtask

   task automatic fill_dst(input logic [7:0] v);
      for (int a = DST; a < DST + 30; a++) poke(a, v);
   endtask

   task automatic load_random();
      logic [15:0] r;
      for (int i = 0; i < 15; i++) begin
         r = 16'($urandom);
         load_msg(i, r[7:0], r[15:8]);
         exp_cw[i] = hamming_pkg::encode11({r[10:8], r[7:0]});
      end
   endtask

   // m counts rising edges after the one that samples req
   task automatic run(input int hold, input int pulse, output int l);
      l = -1;
      @(negedge clk);
      req = 1'b1;
      for (int m = 0; m < 200; m++) begin
         @(negedge clk);
         if (m == 0) check("done_clear", {31'd0, done}, 32'd0);
         if (done) begin
            l = m;
            break;
         end
         req = (m < hold) || (m == pulse);
      end
      req = 1'b0;
   endtask

   task automatic check_all(input string tag);
      logic [15:0] cw;
      for (int i = 0; i < 15; i++) begin
         cw = {mem[DST + 2 * i + 1], mem[DST + 2 * i]};
         check($sformatf("%s_cw%0d", tag, i), {16'd0, cw}, {16'd0, exp_cw[i]});
         check($sformatf("%s_par%0d", tag, i), {31'd0, ^cw}, 32'd0);
      end
   endtask

   initial begin
      reset = 1'b1;
      req = 1'b0;
      ld_en = 1'b0;
      ld_addr = '0;
      ld_data = '0;
      repeat (3) @(negedge clk);
      check("rst_done", {31'd0, done}, 32'd0);
      check("rst_wr_en", {31'd0, mem_wr_en}, 32'd0);
      check("rst_addr", {24'd0, mem_addr}, 32'd0);
      check("rst_wr_data", {24'd0, mem_wr_data}, 32'd0);
      reset = 1'b0;

      for (int i = 0; i < 15; i++) begin
         load_msg(i, 8'h00, 8'h00);
         exp_cw[i] = 16'h0000;
      end
      fill_dst(8'hAA);
      w0 = wr_cnt;
      run(0, -1, lat);
      check("zero_latency", lat, 75);
      check("zero_strobes", wr_cnt - w0, 30);
      check_all("zero");

      load_msg(0, 8'h01, 8'h00);
      load_msg(1, 8'h00, 8'h04);
      load_msg(2, 8'hFF, 8'h07);
      load_msg(3, 8'h00, 8'hF8);
      fill_dst(8'hAA);
      run(0, -1, lat);
      check("dir_latency", lat, 75);
      check("dir_b30", {24'd0, mem[30]}, 32'h0F);
      check("dir_b31", {24'd0, mem[31]}, 32'h00);
      check("dir_b32", {24'd0, mem[32]}, 32'h17);
      check("dir_b33", {24'd0, mem[33]}, 32'h81);
      check("dir_b34", {24'd0, mem[34]}, 32'hFF);
      check("dir_b35", {24'd0, mem[35]}, 32'hFF);
      check("dir_garbage", {16'd0, mem[37], mem[36]}, 32'h0000);

      load_random();
      fill_dst(8'hAA);
      w0 = wr_cnt;
      run(40, 50, lat);
      check("hold_latency", lat, 75);
      check("hold_strobes", wr_cnt - w0, 30);
      check_all("hold");

      load_random();
      fill_dst(8'h55);
      @(negedge clk);
      req = 1'b1;
      for (int m = 0; m <= 38; m++) begin
         @(negedge clk);
         req = 1'b0;
      end
      check("mid_wr_en", {31'd0, mem_wr_en}, 32'd1);
      check("mid_addr", {24'd0, mem_addr}, DST + 14);
      reset = 1'b1;
      @(negedge clk);
      check("rst_mid_done", {31'd0, done}, 32'd0);
      check("rst_mid_wr_en", {31'd0, mem_wr_en}, 32'd0);
      check("rst_mid_addr", {24'd0, mem_addr}, 32'd0);
      reset = 1'b0;
      run(0, -1, lat);
      check("fresh_latency", lat, 75);
      check_all("fresh");

      load_random();
      run(0, -1, lat);
      check("rerun_latency", lat, 75);
      check_all("rerun");

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
